mem_arbiter: RTL and testbench

Sequences the shared byte-wide RAM/IO bus between two requesters: the instruction-fetch port (word reads) and the load/store port (byte, half and word reads and writes).
Arbitrates round-robin on ties. Serialises multi-byte accesses little-endian, one byte per cycle. Throttles IO stores with io_buffer_full.
Sits between the IF unit / load-store buffer and the top-level memory pins.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared byte-wide RAM/IO bus: instruction fetch and load/store,
// round-robin on ties, multi-byte accesses serialised little-endian one byte per cycle.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_en,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {REQ_IF, REQ_LS} req_t;

  state_t      state, state_d;
  req_t        last_grant, last_grant_d;
  req_t        owner, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ic, ic_d;
  logic [2:0]  cc, cc_d;
  logic [31:0] rbuf, rbuf_d;
  logic [31:0] mem_a_d;
  logic [7:0]  mem_dout_d;
  logic        mem_wr_d;
  logic        if_done_d, ls_done_d;
  logic [31:0] if_data_d, ls_rdata_d;

  logic        ls_io, if_elig, ls_elig, grant_ls, accept;
  logic [2:0]  ls_n;

  assign ls_n = (ls_size == 2'b00) ? 3'd1 :
                (ls_size == 2'b01) ? 3'd2 : 3'd4;

  // A requester whose done pulse is showing cannot be re-granted in the same cycle.
  always_comb begin : next_state
    ls_io    = ls_wr && (ls_addr[17:16] == IO_HI);
    if_elig  = if_en && !if_done;
    ls_elig  = ls_en && !ls_done && !(ls_io && io_buffer_full);
    grant_ls = ls_elig && (!if_elig || last_grant == REQ_IF);
    accept   = (state == IDLE) && (if_elig || ls_elig);

    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = (grant_ls && ls_wr) ? WRITE : READ;
      READ:    if (ic == n_q + 3'd1) state_d = IDLE;
      WRITE:   if (ic == n_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    last_grant_d = last_grant;
    owner_d      = owner;
    addr_d       = addr_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
    ic_d         = ic;
    cc_d         = cc;
    rbuf_d       = rbuf;
    mem_a_d      = mem_a;
    mem_dout_d   = mem_dout;
    mem_wr_d     = mem_wr;
    if_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    if_data_d    = if_data;
    ls_rdata_d   = ls_rdata;

    unique case (state)
      IDLE: begin
        if (accept) begin
          owner_d      = grant_ls ? REQ_LS : REQ_IF;
          last_grant_d = owner_d;
          addr_d       = grant_ls ? ls_addr : if_pc;
          n_d          = grant_ls ? ls_n : 3'd4;
          wdata_d      = ls_wdata;
          mem_a_d      = addr_d;
          ic_d         = 3'd1;
          cc_d         = 3'd0;
          rbuf_d       = '0;
          mem_wr_d     = grant_ls && ls_wr;
          if (grant_ls && ls_wr) mem_dout_d = ls_wdata[7:0];
        end
      end

      // ic counts issue edges since accept; bytes land one cycle behind their address.
      READ: begin
        if (ic < n_q) begin
          mem_a_d = mem_a + 32'd1;
          ic_d    = ic + 3'd1;
        end else if (ic == n_q) begin
          mem_a_d = '0;
          ic_d    = ic + 3'd1;
        end
        if (ic >= 3'd2) begin
          rbuf_d[{cc[1:0], 3'b000} +: 8] = mem_din;
          cc_d                           = cc + 3'd1;
        end
        if (ic == n_q + 3'd1) begin
          if (owner == REQ_IF) begin
            if_done_d = 1'b1;
            if_data_d = rbuf_d;
          end else begin
            ls_done_d  = 1'b1;
            ls_rdata_d = rbuf_d;
          end
        end
      end

      WRITE: begin
        if (ic < n_q) begin
          mem_a_d    = addr_q + {29'd0, ic};
          mem_dout_d = wdata_q[{ic[1:0], 3'b000} +: 8];
          ic_d       = ic + 3'd1;
        end else begin
          mem_wr_d  = 1'b0;
          mem_a_d   = '0;
          ls_done_d = 1'b1;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ_IF;
      owner      <= REQ_IF;
      addr_q     <= '0;
      n_q        <= '0;
      wdata_q    <= '0;
      ic         <= '0;
      cc         <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      if_data    <= '0;
      ls_rdata   <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_d;
      last_grant <= last_grant_d;
      owner      <= owner_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      wdata_q    <= wdata_d;
      ic         <= ic_d;
      cc         <= cc_d;
      rbuf       <= rbuf_d;
      mem_a      <= mem_a_d;
      mem_dout   <= mem_dout_d;
      mem_wr     <= mem_wr_d;
      if_done    <= if_done_d;
      ls_done    <= ls_done_d;
      if_data    <= if_data_d;
      ls_rdata   <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bus memory model, directed scenarios, then random
// transactions compared against a byte-array reference model.
module tb_mem_arbiter;

  localparam int          MEM_SIZE = 1 << 18;
  localparam logic [31:0] MASK     = 32'h0003_FFFF;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_en;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_en, ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .ls_en(ls_en), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  logic [7:0]  ram       [MEM_SIZE];
  logic [7:0]  model_mem [MEM_SIZE];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  int total = 0;
  int bad   = 0;

  // Bus memory: one-cycle read latency, frozen along with the arbiter when rdy is low.
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[17:0]];

  always @(negedge clk) begin
    if (mem_wr && rdy) begin
      ram[mem_a[17:0]] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_n(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v, idx;
    v = '0;
    for (int i = 0; i < n; i++) begin
      idx = (a + 32'(i)) & MASK;
      v[8*i +: 8] = model_mem[idx[17:0]];
    end
    return v;
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] d);
    ram[a[17:0]]       = d;
    model_mem[a[17:0]] = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_a"},    mem_a,    32'h0);
    check({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    check({tag, "_mem_wr"},   32'(mem_wr),   32'h0);
    check({tag, "_if_done"},  32'(if_done),  32'h0);
    check({tag, "_ls_done"},  32'(ls_done),  32'h0);
    check({tag, "_if_data"},  if_data,  32'h0);
    check({tag, "_ls_rdata"}, ls_rdata, 32'h0);
  endtask

  // One request from a single requester; checks latency in active edges, data and write bytes.
  task automatic do_req(input bit is_ls, input bit wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd, input bit rnd_rdy);
    int          n, lat;
    bit          seen;
    logic [31:0] exp, idx;
    n = is_ls ? size_n(sz) : 4;
    exp = model_read(a, n);
    wlog_a.delete();
    wlog_d.delete();
    if (is_ls) begin
      ls_en = 1'b1; ls_wr = wr; ls_addr = a; ls_size = sz; ls_wdata = wd;
    end else begin
      if_en = 1'b1; if_pc = a;
    end
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rdy) lat++;
      step();
      seen = is_ls ? ls_done : if_done;
    end
    check("done_seen", 32'(seen), 32'h1);
    if (is_ls) ls_en = 1'b0;
    else       if_en = 1'b0;
    rdy = 1'b1;
    check("latency", 32'(lat), 32'(wr ? n + 1 : n + 2));
    if (!wr) begin
      check(is_ls ? "ls_rdata" : "if_data", is_ls ? ls_rdata : if_data, exp);
    end else begin
      check("wr_count", 32'(wlog_a.size()), 32'(n));
      for (int i = 0; i < n && i < wlog_a.size(); i++) begin
        check("wr_addr", wlog_a[i], a + 32'(i));
        check("wr_byte", 32'(wlog_d[i]), 32'(wd[8*i +: 8]));
      end
      for (int i = 0; i < n; i++) begin
        idx = (a + 32'(i)) & MASK;
        model_mem[idx[17:0]] = wd[8*i +: 8];
      end
    end
    step();
    check("done_cleared", 32'(is_ls ? ls_done : if_done), 32'h0);
  endtask

  initial begin : main
    int          order [$];
    bit          seen;
    logic [31:0] wd;
    logic [31:0] exp_fetch;
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    if_en = 1'b0; if_pc = '0;
    ls_en = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i]       = 8'($urandom);
      model_mem[i] = ram[i];
    end
    put_byte(32'h100, 8'h13); put_byte(32'h101, 8'h05);
    put_byte(32'h102, 8'h00); put_byte(32'h103, 8'h00);
    put_byte(32'h1002, 8'h34); put_byte(32'h1003, 8'h12);
    put_byte(32'h1010, 8'hFF);

    // Both requesters held from reset release: LS, IF, LS, IF.
    if_en = 1'b1; if_pc = 32'h200;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h300; ls_size = 2'b00; ls_wdata = 32'h1234_565A;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      step();
      if (ls_done) order.push_back(1);
      if (if_done) order.push_back(0);
    end
    if_en = 1'b0; ls_en = 1'b0;
    check("rr_events", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check("rr_order", 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    check("rr_if_data", if_data, model_read(32'h200, 4));
    check("rr_wr_count", 32'(wlog_a.size()), 32'd2);
    for (int i = 0; i < wlog_a.size(); i++) begin
      check("rr_wr_addr", wlog_a[i], 32'h300);
      check("rr_wr_byte", 32'(wlog_d[i]), 32'h5A);
    end
    model_mem[32'h300] = 8'h5A;
    repeat (2) step();

    // Directed word fetch at 0x100 with cycle-exact address sequence.
    if_en = 1'b1; if_pc = 32'h100;
    for (int k = 0; k < 5; k++) begin
      step();
      check("fetch_mem_a", mem_a, (k < 4) ? 32'h100 + 32'(k) : 32'h0);
      check("fetch_mem_wr", 32'(mem_wr), 32'h0);
      check("fetch_not_done", 32'(if_done), 32'h0);
    end
    step();
    check("fetch_done", 32'(if_done), 32'h1);
    check("fetch_data", if_data, 32'h0000_0513);
    if_en = 1'b0;
    step();
    check("fetch_done_pulse", 32'(if_done), 32'h0);

    // Half and byte loads, word store.
    do_req(1'b1, 1'b0, 32'h1002, 2'b01, 32'h0, 1'b0);
    check("half_load_value", ls_rdata, 32'h0000_1234);
    do_req(1'b1, 1'b0, 32'h1010, 2'b00, 32'h0, 1'b0);
    check("byte_load_value", ls_rdata, 32'h0000_00FF);
    do_req(1'b1, 1'b1, 32'h2000, 2'b10, 32'hDEAD_BEEF, 1'b0);

    // Word store with a 3-cycle freeze after the second byte.
    wd = 32'hDEAD_BEEF;
    wlog_a.delete(); wlog_d.delete();
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h2000; ls_size = 2'b10; ls_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        rdy = 1'b0;
        repeat (3) begin
          step();
          check("frz_mem_a", mem_a, 32'h2001);
          check("frz_mem_dout", 32'(mem_dout), 32'(wd[15:8]));
          check("frz_mem_wr", 32'(mem_wr), 32'h1);
        end
        rdy = 1'b1;
      end
      step();
      check("frz_st_mem_a", mem_a, 32'h2000 + 32'(i));
      check("frz_st_mem_dout", 32'(mem_dout), 32'(wd[8*i +: 8]));
      check("frz_st_mem_wr", 32'(mem_wr), 32'h1);
    end
    step();
    check("frz_done", 32'(ls_done), 32'h1);
    check("frz_wr_low", 32'(mem_wr), 32'h0);
    check("frz_mem_a_idle", mem_a, 32'h0);
    ls_en = 1'b0;
    check("frz_wr_count", 32'(wlog_a.size()), 32'd4);
    for (int i = 0; i < wlog_a.size() && i < 4; i++) begin
      check("frz_wr_addr", wlog_a[i], 32'h2000 + 32'(i));
      check("frz_wr_byte", 32'(wlog_d[i]), 32'(wd[8*i +: 8]));
    end
    step();

    // IO store stalled by io_buffer_full while a fetch goes through.
    wlog_a.delete(); wlog_d.delete();
    exp_fetch = model_read(32'h400, 4);
    io_buffer_full = 1'b1;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'b00; ls_wdata = 32'h0000_00AB;
    if_en = 1'b1; if_pc = 32'h400;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      seen = if_done;
    end
    if_en = 1'b0;
    check("io_fetch_done", 32'(seen), 32'h1);
    check("io_fetch_data", if_data, exp_fetch);
    repeat (2) step();
    check("io_no_write", 32'(wlog_a.size()), 32'd0);
    io_buffer_full = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      seen = ls_done;
    end
    ls_en = 1'b0;
    check("io_st_done", 32'(seen), 32'h1);
    check("io_wr_count", 32'(wlog_a.size()), 32'd1);
    if (wlog_a.size() > 0) begin
      check("io_wr_addr", wlog_a[0], 32'h0003_0000);
      check("io_wr_byte", 32'(wlog_d[0]), 32'hAB);
    end
    model_mem[32'h30000] = 8'hAB;
    step();

    // Reset in cycle 3 of a fetch, then restart from scratch.
    if_en = 1'b1; if_pc = 32'h100;
    repeat (4) step();
    rst = 1'b0;
    step();
    check_zero("midrst");
    rst = 1'b1;
    step();
    check("restart_mem_a", mem_a, 32'h100);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      seen = if_done;
    end
    if_en = 1'b0;
    check("restart_done", 32'(seen), 32'h1);
    check("restart_data", if_data, 32'h0000_0513);
    step();

    // Address wrap across 2^32.
    do_req(1'b0, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_C3A5, 1'b0);

    // Random traffic with random freezes.
    for (int t = 0; t < 30; t++) begin
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 2);
      a    = 32'($urandom_range(0, 32'h2FFF0));
      case (kind)
        0:       do_req(1'b0, 1'b0, a, 2'b10, 32'h0, 1'b1);
        1:       do_req(1'b1, 1'b0, a, 2'($urandom), 32'h0, 1'b1);
        default: do_req(1'b1, 1'b1, a, 2'($urandom), $urandom, 1'b1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
